// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Holds the fetch PC and issues word
//               requests over a req/gnt/rvalid interface, keeping at most
//               one request outstanding. Returned words and their PCs go
//               into a 2-entry queue toward decode. A redirect from decode
//               flushes the queue, restarts fetch at the new target and
//               discards any response still in flight.
// Ports       : clk, rst_n (async, active low)
//               imem_req/imem_addr/imem_gnt     - request channel
//               imem_rvalid/imem_rdata          - response channel
//               redirect/redirect_pc            - restart strobe and target
//               instr_valid/instr/instr_pc/instr_ready - queue head to decode
//               misalign                        - misaligned-target trap flag
// Config      : `define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect
//               targets in a HALT state; otherwise the low target bits are
//               ignored and misalign is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        misalign
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    ST_HALT = 2'd3
`endif
  } state_t;

  state_t      r_state;
  logic [31:0] r_fpc;
  logic [31:0] r_out_pc;
  logic [1:0]  r_count;
  logic [31:0] r_q_pc    [2];
  logic [31:0] r_q_instr [2];

  logic        w_grant;
  logic        w_push;
  logic        w_pop;
  logic        w_busy_after;
  logic [31:0] w_target;

  // Only request while a queue slot is guaranteed for the response.
  assign imem_req  = (r_state == ST_REQ) && (r_count != 2'd2);
  assign imem_addr = r_fpc;
  assign w_grant   = imem_req && imem_gnt;

  // The queue head is hidden during a redirect so nothing is popped.
  assign instr_valid = (r_count != 2'd0) && !redirect;
  assign instr       = r_q_instr[0];
  assign instr_pc    = r_q_pc[0];

  // Push/pop are only acted on outside a redirect cycle.
  assign w_push = (r_state == ST_WAIT) && imem_rvalid;
  assign w_pop  = (r_count != 2'd0) && instr_ready;

  // A response is still owed after a redirect if one was outstanding and did
  // not arrive this cycle, or if a request is being granted right now.
  assign w_busy_after = (((r_state == ST_WAIT) || (r_state == ST_DROP)) && !imem_rvalid)
                        || w_grant;

  assign w_target = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_misalign;
  logic w_misaligned;
  assign w_misaligned = (redirect_pc[1:0] != 2'b00);
  assign misalign     = r_misalign;
`else
  logic w_unused_low_bits;
  assign w_unused_low_bits = ^redirect_pc[1:0];
  assign misalign          = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_REQ;
      r_fpc        <= RESET_PC;
      r_out_pc     <= '0;
      r_count      <= '0;
      r_q_pc[0]    <= '0;
      r_q_pc[1]    <= '0;
      r_q_instr[0] <= '0;
      r_q_instr[1] <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      r_misalign   <= 1'b0;
`endif
    end else if (redirect) begin
      r_count <= 2'd0;
      r_fpc   <= w_target;
      if (w_busy_after) begin
        r_state <= ST_DROP;
`ifdef FETCH_MISALIGN_TRAP_EN
      end else if (w_misaligned) begin
        r_state <= ST_HALT;
`endif
      end else begin
        r_state <= ST_REQ;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      // Held through DROP so the discard completes before halting.
      r_misalign <= w_misaligned;
`endif
    end else begin
      case (r_state)
        ST_REQ: begin
          if (w_grant) begin
            r_out_pc <= r_fpc;
            r_fpc    <= r_fpc + 32'd4;
            r_state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) r_state <= ST_REQ;
        end
        ST_DROP: begin
          if (imem_rvalid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            r_state <= r_misalign ? ST_HALT : ST_REQ;
`else
            r_state <= ST_REQ;
`endif
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase

      // Requests are gated on a free slot, so a push never sees count==2.
      case ({w_push, w_pop})
        2'b10: begin
          r_q_pc[r_count[0]]    <= r_out_pc;
          r_q_instr[r_count[0]] <= imem_rdata;
          r_count               <= r_count + 2'd1;
        end
        2'b01: begin
          r_q_pc[0]    <= r_q_pc[1];
          r_q_instr[0] <= r_q_instr[1];
          r_count      <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_q_pc[0]    <= r_out_pc;
            r_q_instr[0] <= imem_rdata;
          end else begin
            r_q_pc[0]    <= r_q_pc[1];
            r_q_instr[0] <= r_q_instr[1];
            r_q_pc[1]    <= r_out_pc;
            r_q_instr[1] <= imem_rdata;
          end
        end
        default: begin
          r_count <= r_count;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the branch/PC-update logic in decode. Holds the architectural fetch PC, issues word requests to instruction memory over a request/grant/response interface, and buffers returned instructions with their PCs in a 2-entry queue toward decode. Decode's resolved next-PC comes back as a redirect that flushes in-flight work and restarts fetch.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  asynchronous active-low reset
- IMEM_REQ  out  1  fetch request valid
- IMEM_ADDR  out  32  word address of request (bits [1:0] always 0)
- IMEM_GNT  in  1  memory accepts request this cycle
- IMEM_RVALID  in  1  response data valid
- IMEM_RDATA  in  32  instruction word
- REDIRECT  in  1  single-cycle strobe: restart fetch at REDIRECT_PC
- REDIRECT_PC  in  32  new fetch target (NEXTPC from branch logic)
- INSTR_VALID  out  1  queue head valid toward decode
- INSTR  out  32  queue head instruction
- INSTR_PC  out  32  PC of queue head
- INSTR_READY  in  1  decode consumes head when high with INSTR_VALID
- MISALIGN  out  1  misaligned redirect target (only with FETCH_MISALIGN_TRAP_EN; else tied 0)

## Operation
- Registers: FPC (next address to request), state, queue (2 × {pc, instr}), count (0-2), PC of outstanding request.
- States: REQ (IMEM_REQ=1, IMEM_ADDR=FPC), WAIT (one request outstanding), DROP (outstanding response to discard), HALT (macro only).
- REQ: request only while count < 2, so every response has a free slot; IMEM_REQ=0 when count==2. On IMEM_GNT: latch FPC as outstanding PC, FPC += 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), go WAIT.
- WAIT: on IMEM_RVALID push {outstanding PC, IMEM_RDATA}, go REQ. Max one outstanding request.
- Pop: INSTR_VALID && INSTR_READY removes head; push and pop in same cycle leave count unchanged.
- REDIRECT (priority over everything): queue flushed (count=0), FPC=REDIRECT_PC; state → DROP if a request is outstanding and IMEM_RVALID not high this cycle, else REQ. INSTR_VALID forced 0 in redirect cycle (no pop occurs). Response arriving in the redirect cycle is discarded.
- DROP: on IMEM_RVALID discard data, go REQ. REDIRECT in DROP updates FPC, stays DROP.
- Grant in redirect cycle: request is considered outstanding → DROP.

## Timing
- Reset (async assert): FPC=RESET_PC, state REQ, count=0, IMEM_REQ=1 and IMEM_ADDR=RESET_PC immediately, INSTR_VALID=0, INSTR=0, INSTR_PC=0, MISALIGN=0.
- Grant at cycle n, IMEM_RVALID earliest n+1, INSTR_VALID earliest n+2 (queue registered). Next IMEM_REQ earliest n+2; peak throughput 1 instruction / 2 cycles.
- REDIRECT at cycle r, no outstanding request: IMEM_REQ with REDIRECT_PC at r+1.
- IMEM_REQ held with stable IMEM_ADDR until IMEM_GNT unless REDIRECT changes it.
- INSTR/INSTR_PC stable while INSTR_VALID && !INSTR_READY.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: REDIRECT_PC[1:0]!=0 → state HALT, IMEM_REQ=0, MISALIGN=1 from next cycle, queue flushed; outstanding response still discarded first (DROP precedes HALT). Only an aligned REDIRECT or reset leaves HALT.
- Undefined: REDIRECT_PC[1:0] ignored (forced 0), no HALT state, MISALIGN constant 0.

## Test plan
- Reset release, GNT every REQ cycle, RVALID 1 cycle later, READY=1 -> INSTR_PC sequence 0x0,0x4,0x8 with INSTR matching RDATA, one every 2 cycles.
- READY=0 for 10 cycles -> exactly 2 entries queued, IMEM_REQ drops to 0, FPC=0x8; READY=1 drains 0x0 then 0x4 in order.
- REDIRECT to 0x100 while WAIT, RVALID 3 cycles later with 0xDEADBEEF -> data discarded, next request at 0x100, first INSTR_PC=0x100.
- REDIRECT same cycle as INSTR_VALID&&INSTR_READY and IMEM_RVALID -> no pop, no push, count=0, next IMEM_ADDR=REDIRECT_PC.
- FPC=0xFFFF_FFFC granted -> next IMEM_ADDR=0x0.
- With FETCH_MISALIGN_TRAP_EN: REDIRECT_PC=0x102 -> MISALIGN=1, IMEM_REQ=0; then REDIRECT_PC=0x200 -> MISALIGN=0, request at 0x200.
